// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: x - y - bin, DIGIT bits per clock, borrow registered between digits.
// Optional zero/neg result flags are enabled by defining SERIAL_SUBTRACTOR_FLAGS_EN.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2) begin : g_width_check
            $fatal(1, "serial_subtractor: WIDTH must be at least 2");
        end
        if (WIDTH % DIGIT != 0) begin : g_digit_check
            $fatal(1, "serial_subtractor: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] mask_w;
    logic [DIGIT-1:0] diff;
    logic [CW-1:0]    cnt;
    logic [31:0]      shamt;
    logic             borrow_q;
    logic             borrow_dig;
    logic             b;
    logic             last_digit;
    logic             accept;
    logic             ovf_q;
    logic             ovf_next;

    assign shamt      = 32'(cnt) * 32'(DIGIT);
    assign last_digit = (cnt == CW'(NDIG - 1));
    assign accept     = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Full-subtractor ripple across the current digit; the borrow entering it comes from the register.
    always_comb begin
        x_sh = x_q >> shamt;
        y_sh = y_q >> shamt;
        diff = '0;
        b    = borrow_q;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i] = x_sh[i] ^ y_sh[i] ^ b;
            b       = (~x_sh[i] & y_sh[i]) | (~x_sh[i] & b) | (y_sh[i] & b);
        end
        borrow_dig = b;
        diff_w     = '0;
        diff_w[DIGIT-1:0] = diff;
        mask_w     = '0;
        mask_w[DIGIT-1:0] = '1;
        d_next     = (d_q & ~(mask_w << shamt)) | (diff_w << shamt);
        ovf_next   = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (d_next[WIDTH-1] ^ x_q[WIDTH-1]);
    end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic zero_q;
    logic neg_q;
`endif

    // Flags are only refreshed on the final digit so they hold steady with the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            d_q      <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else if (accept) begin
            x_q      <= x;
            y_q      <= y;
            borrow_q <= bin;
            cnt      <= '0;
        end else if (state == RUN) begin
            d_q      <= d_next;
            borrow_q <= borrow_dig;
            cnt      <= cnt + 1'b1;
            if (last_digit) begin
                ovf_q  <= ovf_next;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                zero_q <= (d_next == '0);
                neg_q  <= d_next[WIDTH-1] ^ ovf_next;
`endif
            end
        end
    end

    assign d    = d_q;
    assign bout = borrow_q;
    assign ovf  = ovf_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    assign zero = zero_q;
    assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit bit-serial instance and a 16-bit nibble-serial instance.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic        bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  d8;
    logic        bout8;
    logic        ovf8;
    logic        start16;
    logic [15:0] x16;
    logic [15:0] y16;
    logic        bin16;
    logic        busy16;
    logic        done16;
    logic [15:0] d16;
    logic        bout16;
    logic        ovf16;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic        zero8;
    logic        neg8;
    logic        zero16;
    logic        neg16;
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .x     (x8),
        .y     (y8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
        .bout  (bout8),
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        .zero  (zero8),
        .neg   (neg8),
`endif
        .ovf   (ovf8)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .x     (x16),
        .y     (y16),
        .bin   (bin16),
        .busy  (busy16),
        .done  (done16),
        .d     (d16),
        .bout  (bout16),
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        .zero  (zero16),
        .neg   (neg16),
`endif
        .ovf   (ovf16)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs8[8];
    vec_t vecs16[3];

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for exactly one edge.
    task automatic applyStimulus(input logic sel, input logic [15:0] xv, input logic [15:0] yv, input logic bv);
        if (sel) begin
            start16 = 1'b1; x16 = xv; y16 = yv; bin16 = bv;
        end else begin
            start8 = 1'b1; x8 = xv[7:0]; y8 = yv[7:0]; bin8 = bv;
        end
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic waitDone(input logic sel, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (!(sel ? done16 : done8) && cycles < 40) begin
            if (sel ? busy16 : busy8) busy_cycles++;
            tick();
            cycles++;
        end
    endtask

    task automatic checkResult(input logic sel, input string tag, input vec_t v);
        if (sel) begin
            checkOutput({tag, "_d"},    d16,    v.d);
            checkOutput({tag, "_bout"}, bout16, v.bout);
            checkOutput({tag, "_ovf"},  ovf16,  v.ovf);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            checkOutput({tag, "_zero"}, zero16, v.zero);
            checkOutput({tag, "_neg"},  neg16,  v.neg);
`endif
        end else begin
            checkOutput({tag, "_d"},    d8,    v.d);
            checkOutput({tag, "_bout"}, bout8, v.bout);
            checkOutput({tag, "_ovf"},  ovf8,  v.ovf);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            checkOutput({tag, "_zero"}, zero8, v.zero);
            checkOutput({tag, "_neg"},  neg8,  v.neg);
`endif
        end
    endtask

    task automatic runVector(input logic sel, input string tag, input vec_t v, input int lat);
        int cycles;
        int busy_cycles;
        applyStimulus(sel, v.x, v.y, v.bin);
        waitDone(sel, cycles, busy_cycles);
        checkOutput({tag, "_latency"}, cycles, lat);
        checkOutput({tag, "_busy_len"}, busy_cycles, lat);
        checkResult(sel, tag, v);
        tick();
        checkOutput({tag, "_done_pulse"}, sel ? done16 : done8, 1'b0);
    endtask

    initial begin
        int    cycles;
        int    busy_cycles;
        int    done_seen;
        vec_t  v;

        //                 x        y        bin   d        bout  ovf   zero  neg
        vecs8[0]  = '{16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs8[1]  = '{16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs8[2]  = '{16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs8[3]  = '{16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs8[4]  = '{16'h10, 16'h10, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs8[5]  = '{16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs8[6]  = '{16'hA5, 16'h5A, 1'b1, 16'h4A, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs8[7]  = '{16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs16[0] = '{16'h1234, 16'h0FFF, 1'b1, 16'h0234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs16[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs16[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; x8 = '0; y8 = '0; bin8 = 1'b0;
        start16 = 1'b0; x16 = '0; y16 = '0; bin16 = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", busy8, 1'b0);
        checkOutput("reset_done", done8, 1'b0);
        checkOutput("reset_d",    d8,    8'h00);
        checkOutput("reset_bout", bout8, 1'b0);
        checkOutput("reset_ovf",  ovf8,  1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            runVector(1'b0, $sformatf("v8_%0d", i), vecs8[i], 8);
        end

        // Start held through RUN must not recapture; held into DONE it starts the next op immediately.
        start8 = 1'b1; x8 = 8'h40; y8 = 8'h01; bin8 = 1'b0;
        tick();
        x8 = 8'hFF; y8 = 8'hFF;
        waitDone(1'b0, cycles, busy_cycles);
        checkOutput("hold_latency", cycles, 8);
        v = '{16'h3F, 16'h0, 1'b0, 16'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
        v.x = 16'h40; v.y = 16'h01;
        checkResult(1'b0, "hold_first", v);
        tick();
        checkOutput("b2b_busy", busy8, 1'b1);
        checkOutput("b2b_done", done8, 1'b0);
        start8 = 1'b0;
        waitDone(1'b0, cycles, busy_cycles);
        checkOutput("b2b_latency", cycles, 8);
        v = '{16'hFF, 16'hFF, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        checkResult(1'b0, "b2b_second", v);
        tick();

        for (int i = 0; i < 3; i++) begin
            runVector(1'b1, $sformatf("v16_%0d", i), vecs16[i], 4);
        end

        // Abort during the third RUN cycle; the two digits already written leave d nonzero.
        applyStimulus(1'b0, 16'hF0, 16'h0F, 1'b0);
        checkOutput("abort_busy_run", busy8, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_busy", busy8, 1'b0);
        checkOutput("abort_done", done8, 1'b0);
        checkOutput("abort_d",    d8,    8'h00);
        checkOutput("abort_bout", bout8, 1'b0);
        checkOutput("abort_ovf",  ovf8,  1'b0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) done_seen++;
            tick();
        end
        checkOutput("abort_no_done", done_seen, 0);
        runVector(1'b0, "after_abort", vecs8[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
